ahb2_mem_arbiter: RTL and testbench

//   Shares one AHB2 memory slave (the AHB2 SRAM model, or any AHB-lite slave) between
//   NUM_MST AHB-lite masters.
//   - Each master sees a private slave port. Accepted address phases are captured into
//     per-master pending registers.
//   - Pending transfers are issued one per beat onto a single master port.
//   - Write data, read data, ready and response are routed back to the owning master.
//   - Sits between the CPU/DMA bus masters and the shared memory in the simulation SoC.
//

---
 rtl/ahb2_mem_arbiter_if.sv | 45 ++++
 rtl/ahb2_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ahb2_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2_mem_arbiter_if.sv
// Bus bundle for ahb2_mem_arbiter: NUM_MST upstream AHB-lite slave ports (s_*)
// flattened per master, plus the single downstream master port (m_*).
// modport slave  : the arbiter side.
// modport master : the environment side (upstream masters and the memory).
interface ahb2_mem_arbiter_if #(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_MST-1:0]            s_hsel;
  logic [2*NUM_MST-1:0]          s_htrans;
  logic [NUM_MST*ADDR_WIDTH-1:0] s_haddr;
  logic [NUM_MST-1:0]            s_hwrite;
  logic [3*NUM_MST-1:0]          s_hsize;
  logic [NUM_MST*DATA_WIDTH-1:0] s_hwdata;
  logic [NUM_MST-1:0]            s_hreadyi;
  logic [NUM_MST-1:0]            s_hreadyo;
  logic [NUM_MST-1:0]            s_hresp;
  logic [DATA_WIDTH-1:0]         s_hrdata;

  logic                          m_hsel;
  logic [1:0]                    m_htrans;
  logic [ADDR_WIDTH-1:0]         m_haddr;
  logic                          m_hwrite;
  logic [2:0]                    m_hsize;
  logic [DATA_WIDTH-1:0]         m_hwdata;
  logic                          m_hreadyi;
  logic [DATA_WIDTH-1:0]         m_hrdata;
  logic                          m_hreadyo;
  logic                          m_hresp;

  modport slave (
    input  s_hsel, s_htrans, s_haddr, s_hwrite, s_hsize, s_hwdata, s_hreadyi,
    output s_hreadyo, s_hresp, s_hrdata,
    output m_hsel, m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata, m_hreadyi,
    input  m_hrdata, m_hreadyo, m_hresp
  );

  modport master (
    output s_hsel, s_htrans, s_haddr, s_hwrite, s_hsize, s_hwdata, s_hreadyi,
    input  s_hreadyo, s_hresp, s_hrdata,
    input  m_hsel, m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata, m_hreadyi,
    output m_hrdata, m_hreadyo, m_hresp
  );
endinterface

// File: rtl/ahb2_mem_arbiter.sv
// ahb2_mem_arbiter: shares one AHB-lite memory slave between NUM_MST masters.
// Each master's address phase is captured into a pending register, then issued
// as a single NONSEQ beat on the memory port; data phase signals are routed
// back to the owning master. One wait state per uncontended transfer.
//
// Build option: AHB2_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of the default round-robin grant.
//
// Per-master state table:
//   state     | meaning
//   ST_IDLE   | no transfer held; ready high, can capture
//   ST_PEND   | address captured, waiting for grant; ready low
//   ST_ACTIVE | owns the memory data phase; ready/resp follow memory
module ahb2_mem_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  ahb2_mem_arbiter_if.slave  bus
);

  localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                state_q     [NUM_MST];
  logic [ADDR_WIDTH-1:0] pend_addr_q [NUM_MST];
  logic [NUM_MST-1:0]    pend_write_q;
  logic [2:0]            pend_size_q [NUM_MST];

  logic [ADDR_WIDTH-1:0] haddr_hold_q;
  logic                  hwrite_hold_q;
  logic [2:0]            hsize_hold_q;
`ifndef AHB2_ARB_FIXED_PRIO_EN
  logic [IW-1:0]         last_grant_q;
  logic [IW-1:0]         cand;
  logic                  found;
`endif

  logic [NUM_MST-1:0]    capture;
  logic [NUM_MST-1:0]    pend_vec;
  logic                  active_any;
  logic                  issue;
  logic [IW-1:0]         gnt;
  logic                  unused_htrans_lsb;

  // Capture qualifiers and pending/active summary across masters
  always_comb begin
    capture           = '0;
    pend_vec          = '0;
    active_any        = 1'b0;
    unused_htrans_lsb = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      pend_vec[i] = (state_q[i] == ST_PEND);
      if (state_q[i] == ST_ACTIVE) active_any = 1'b1;
      // A master may be re-captured in the very cycle its own data phase ends.
      capture[i] = bus.s_hsel[i] & bus.s_htrans[2*i+1] & bus.s_hreadyi[i] &
                   ((state_q[i] == ST_IDLE) |
                    ((state_q[i] == ST_ACTIVE) & bus.m_hreadyo));
      // SEQ and NONSEQ are treated alike, so htrans[0] carries no information.
      unused_htrans_lsb = unused_htrans_lsb ^ bus.s_htrans[2*i];
    end
  end

  // Grant selection among pending masters
  always_comb begin
    gnt = '0;
`ifdef AHB2_ARB_FIXED_PRIO_EN
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (pend_vec[i]) gnt = IW'(i);
    end
`else
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NUM_MST);
      if (!found && pend_vec[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
`endif
  end

  // Issue only when the data phase slot is free or freeing up this cycle
  assign issue = (|pend_vec) & (~active_any | bus.m_hreadyo);

  // Memory-side address phase comes purely from registered pending state
  always_comb begin
    bus.m_hsel    = issue;
    bus.m_htrans  = issue ? 2'b10 : 2'b00;
    bus.m_haddr   = issue ? pend_addr_q[gnt]  : haddr_hold_q;
    bus.m_hwrite  = issue ? pend_write_q[gnt] : hwrite_hold_q;
    bus.m_hsize   = issue ? pend_size_q[gnt]  : hsize_hold_q;
    bus.m_hwdata  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (state_q[i] == ST_ACTIVE)
        bus.m_hwdata = bus.s_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Per-master ready/response: only the data-phase owner sees the memory
  always_comb begin
    bus.s_hreadyo = '1;
    bus.s_hresp   = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      case (state_q[i])
        ST_PEND:   bus.s_hreadyo[i] = 1'b0;
        ST_ACTIVE: begin
          bus.s_hreadyo[i] = bus.m_hreadyo;
          bus.s_hresp[i]   = bus.m_hresp;
        end
        default:   bus.s_hreadyo[i] = 1'b1;
      endcase
    end
  end

  assign bus.s_hrdata  = bus.m_hrdata;
  assign bus.m_hreadyi = bus.m_hreadyo;

  // Per-master FSMs, pending registers, address hold and grant pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MST; i++) begin
        state_q[i]     <= ST_IDLE;
        pend_addr_q[i] <= '0;
        pend_size_q[i] <= '0;
      end
      pend_write_q  <= '0;
      haddr_hold_q  <= '0;
      hwrite_hold_q <= 1'b0;
      hsize_hold_q  <= '0;
`ifndef AHB2_ARB_FIXED_PRIO_EN
      last_grant_q  <= IW'(NUM_MST - 1);
`endif
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        case (state_q[i])
          ST_IDLE:   if (capture[i]) state_q[i] <= ST_PEND;
          ST_PEND:   if (issue && (gnt == IW'(i))) state_q[i] <= ST_ACTIVE;
          ST_ACTIVE: if (bus.m_hreadyo) state_q[i] <= capture[i] ? ST_PEND : ST_IDLE;
          default:   state_q[i] <= ST_IDLE;
        endcase
        if (capture[i]) begin
          pend_addr_q[i]  <= bus.s_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          pend_write_q[i] <= bus.s_hwrite[i];
          pend_size_q[i]  <= bus.s_hsize[3*i +: 3];
        end
      end
      if (issue) begin
        haddr_hold_q  <= pend_addr_q[gnt];
        hwrite_hold_q <= pend_write_q[gnt];
        hsize_hold_q  <= pend_size_q[gnt];
`ifndef AHB2_ARB_FIXED_PRIO_EN
        last_grant_q  <= gnt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb2_mem_arbiter.sv
// Self-checking bench for ahb2_mem_arbiter with two pipelined master BFMs,
// a zero-wait memory model with wait-state injection, and a scoreboard of
// expected read data / wait counts keyed per master.
module tb_ahb2_mem_arbiter;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
  } cmd_t;

  typedef struct {
    int          c;
    logic [31:0] a;
  } iss_t;

  localparam int LIMIT = 400;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   stall_req;

  cmd_t cmd_q [2][$];
  cmd_t exp_q [2][$];
  int   cap_q [2][$];
  iss_t iss_q [$];
  logic busy     [2];
  int   done_cyc [2];

  bit [31:0] ref_mem [bit [31:0]];
  bit [31:0] mem     [bit [31:0]];

  ahb2_mem_arbiter_if #(.NUM_MST(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb2_mem_arbiter #(.NUM_MST(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.s_hreadyi = bus.s_hreadyo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h required %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit [31:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic queue_cmd(input int m, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int waits);
    cmd_t c;
    c.wr = wr; c.addr = a; c.waits = waits;
    if (wr) begin
      ref_mem[a] = d;
      c.data = d;
    end else begin
      c.data = ref_rd(a);
    end
    cmd_q[m].push_back(c);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((cmd_q[0].size() != 0 || cmd_q[1].size() != 0 || busy[0] || busy[1]) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk("wait_timeout", 32'(n), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    iss_q.delete();
    cap_q[0].delete();
    cap_q[1].delete();
  endtask

  // Pipelined AHB-lite master BFM per port
  for (genvar g = 0; g < 2; g++) begin : g_bfm
    logic        sel;
    logic [1:0]  htr;
    logic [31:0] addr_d;
    logic        wr_d;
    logic [31:0] wdat_d;

    assign bus.s_hsel[g]          = sel;
    assign bus.s_htrans[2*g +: 2] = htr;
    assign bus.s_haddr[32*g +: 32] = addr_d;
    assign bus.s_hwrite[g]        = wr_d;
    assign bus.s_hsize[3*g +: 3]  = 3'b010;
    assign bus.s_hwdata[32*g +: 32] = wdat_d;

    initial begin
      logic have_a, have_d;
      cmd_t a, d, e;
      int   waits;
      have_a = 1'b0; have_d = 1'b0; waits = 0;
      sel = 1'b0; htr = 2'b00; addr_d = '0; wr_d = 1'b0; wdat_d = '0;
      busy[g] = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          have_a = 1'b0; have_d = 1'b0; waits = 0;
          cmd_q[g].delete();
          exp_q[g].delete();
        end else if (bus.s_hreadyo[g]) begin
          if (have_d) begin
            e = exp_q[g].pop_front();
            if (!e.wr) chk($sformatf("m%0d_rdata_%h", g, e.addr), bus.s_hrdata, e.data);
            if (e.waits >= 0) chk($sformatf("m%0d_waits_%h", g, e.addr), 32'(waits), 32'(e.waits));
            chk($sformatf("m%0d_hresp", g), 32'(bus.s_hresp[g]), 32'(0));
            done_cyc[g] = cyc;
          end
          have_d = have_a;
          if (have_a) begin
            d = a;
            exp_q[g].push_back(a);
            cap_q[g].push_back(cyc);
          end
          have_a = 1'b0;
          waits  = 0;
        end else if (have_d) begin
          waits++;
        end
        busy[g] = have_a || have_d;
        @(posedge clk); #1;
        if (!have_a && rst_n && cmd_q[g].size() != 0) begin
          a = cmd_q[g].pop_front();
          have_a = 1'b1;
        end
        busy[g] = have_a || have_d;
        sel    = have_a;
        htr    = have_a ? 2'b10 : 2'b00;
        addr_d = have_a ? a.addr : 32'h0;
        wr_d   = have_a ? a.wr : 1'b0;
        wdat_d = (have_d && d.wr) ? d.data : 32'h0;
      end
    end
  end

  // Memory model with optional wait states, plus issue monitor
  initial begin
    bit          dv, dw;
    bit [31:0]   da;
    int          dwait;
    logic        acc, fin, rs, nw;
    logic [31:0] na, nwd;
    dv = 1'b0; dw = 1'b0; da = '0; dwait = 0;
    bus.m_hreadyo = 1'b1; bus.m_hrdata = '0; bus.m_hresp = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.m_hsel & bus.m_htrans[1] & bus.m_hreadyi;
      fin = dv & bus.m_hreadyo;
      na  = bus.m_haddr;
      nw  = bus.m_hwrite;
      nwd = bus.m_hwdata;
      rs  = !rst_n;
      if (acc && !rs) iss_q.push_back('{c: cyc, a: na});
      @(posedge clk); #1;
      if (rs) begin
        dv = 1'b0; dwait = 0;
      end else begin
        if (fin && dw) mem[da] = nwd;
        if (dv && dwait > 0) begin
          dwait--;
        end else begin
          dv = acc;
          if (acc) begin
            da = na; dw = nw; dwait = stall_req; stall_req = 0;
          end
        end
      end
      bus.m_hreadyo = !dv || (dwait == 0);
      bus.m_hrdata  = (dv && !dw) ? mem_rd(da) : 32'h0;
    end
  end

  initial begin
    logic [31:0] a;
    cyc = 0; n_vec = 0; n_err = 0; stall_req = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_hreadyo", 32'(bus.s_hreadyo), 32'h3);
    chk("rst_s_hresp",   32'(bus.s_hresp),   32'h0);
    chk("rst_m_hsel",    32'(bus.m_hsel),    32'h0);
    chk("rst_m_htrans",  32'(bus.m_htrans),  32'h0);
    chk("rst_m_haddr",   bus.m_haddr,        32'h0);
    chk("rst_m_hwdata",  bus.m_hwdata,       32'h0);

    // write then read back on master 0
    queue_cmd(0, 1'b1, 32'h100, 32'hDEADBEEF, 1);
    queue_cmd(0, 1'b0, 32'h100, 32'h0, 1);
    wait_done();
    chk("t1_issue_count", 32'(iss_q.size()), 32'd2);
    for (int i = 0; i < 2 && i < iss_q.size() && i < cap_q[0].size(); i++) begin
      chk($sformatf("t1_addr%0d", i), iss_q[i].a, 32'h100);
      chk($sformatf("t1_issue_cyc%0d", i), 32'(iss_q[i].c), 32'(cap_q[0][i] + 1));
    end
    iss_q.delete(); cap_q[0].delete(); cap_q[1].delete();

    // contended capture with last grant on master 0
    queue_cmd(0, 1'b0, 32'h100, 32'h0, -1);
    queue_cmd(1, 1'b0, 32'h104, 32'h0, -1);
    wait_done();
    chk("t2b_issue_count", 32'(iss_q.size()), 32'd2);
    if (cap_q[0].size() > 0 && cap_q[1].size() > 0)
      chk("t2b_same_capture", 32'(cap_q[1][0]), 32'(cap_q[0][0]));
`ifdef AHB2_ARB_FIXED_PRIO_EN
    if (iss_q.size() > 0) chk("t2b_first_grant", iss_q[0].a, 32'h100);
`else
    if (iss_q.size() > 0) chk("t2b_first_grant", iss_q[0].a, 32'h104);
`endif

    // simultaneous capture after reset
    do_reset();
    queue_cmd(0, 1'b0, 32'h0, 32'h0, 1);
    queue_cmd(1, 1'b0, 32'h4, 32'h0, 2);
    wait_done();
    chk("t2_issue_count", 32'(iss_q.size()), 32'd2);
    if (iss_q.size() == 2 && cap_q[0].size() > 0 && cap_q[1].size() > 0) begin
      chk("t2_m0_addr", iss_q[0].a, 32'h0);
      chk("t2_m0_cyc",  32'(iss_q[0].c), 32'(cap_q[0][0] + 1));
      chk("t2_m1_addr", iss_q[1].a, 32'h4);
      chk("t2_m1_cyc",  32'(iss_q[1].c), 32'(cap_q[1][0] + 2));
    end

    // 8 back-to-back writes per master, alternating grants, then readback
    do_reset();
    for (int k = 0; k < 8; k++) begin
      queue_cmd(0, 1'b1, 32'h1000 + 32'(4*k), $urandom, -1);
      queue_cmd(1, 1'b1, 32'h2000 + 32'(4*k), $urandom, -1);
    end
    wait_done();
    chk("t3_issue_count", 32'(iss_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < iss_q.size(); i++) begin
      a = ((i % 2) == 1 ? 32'h2000 : 32'h1000) + 32'(4 * (i / 2));
      chk($sformatf("t3_order%0d", i), iss_q[i].a, a);
    end
    for (int k = 0; k < 8; k++) begin
      a = 32'h1000 + 32'(4*k);
      chk($sformatf("t3_mem_%h", a), mem_rd(a), ref_rd(a));
      a = 32'h2000 + 32'(4*k);
      chk($sformatf("t3_mem_%h", a), mem_rd(a), ref_rd(a));
      queue_cmd(0, 1'b0, 32'h1000 + 32'(4*k), 32'h0, -1);
      queue_cmd(1, 1'b0, 32'h2000 + 32'(4*k), 32'h0, -1);
    end
    wait_done();

    // memory wait states during master 0 data phase with master 1 pending
    do_reset();
    stall_req = 3;
    queue_cmd(0, 1'b1, 32'h300, 32'h12345678, 4);
    @(negedge clk);
    queue_cmd(1, 1'b0, 32'h300, 32'h0, -1);
    wait_done();
    chk("t4_issue_count", 32'(iss_q.size()), 32'd2);
    if (iss_q.size() == 2) begin
      chk("t4_m1_addr", iss_q[1].a, 32'h300);
      chk("t4_m1_on_completion", 32'(iss_q[1].c), 32'(done_cyc[0]));
    end

    // reset while master 0 active and master 1 pending
    do_reset();
    stall_req = 5;
    queue_cmd(0, 1'b1, 32'h500, 32'hA5A5A5A5, -1);
    @(negedge clk);
    queue_cmd(1, 1'b1, 32'h600, 32'h5A5A5A5A, -1);
    for (int n = 0; n < LIMIT && iss_q.size() == 0; n++) @(negedge clk);
    chk("t5_m0_issued", 32'(iss_q.size()), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_s_hreadyo", 32'(bus.s_hreadyo), 32'h3);
    chk("t5_m_htrans",  32'(bus.m_htrans),  32'h0);
    chk("t5_m_hsel",    32'(bus.m_hsel),    32'h0);
    ref_mem.delete(32'h500);
    ref_mem.delete(32'h600);
    iss_q.delete(); cap_q[0].delete(); cap_q[1].delete();
    stall_req = 0;
    queue_cmd(1, 1'b0, 32'h704, 32'h0, -1);
    queue_cmd(0, 1'b0, 32'h700, 32'h0, -1);
    wait_done();
    chk("t5_issue_count", 32'(iss_q.size()), 32'd2);
    if (iss_q.size() > 0) chk("t5_first_grant", iss_q[0].a, 32'h700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed %0d required 0", cyc);
    $fatal(1, "global timeout");
  end

endmodule
